// File: rtl/mod_reduce128.sv
`default_nettype none
// ============================================================================
//  Module      : mod_reduce128
//  Description : Bit-serial restoring modular reduction R = P mod M, where P
//                is a 2*WIDTH-bit product and M a WIDTH-bit modulus. One
//                dividend bit is consumed per cycle behind valid/ready
//                handshakes on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_reduce128 #(
  parameter int WIDTH = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] in_p,
  input  logic [WIDTH-1:0]   in_m,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_r,
  output logic               out_err,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(PW + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH:0]    r_q, r_d;        // partial remainder, one spare bit for the shift
  logic [WIDTH-1:0]  m_q, m_d;        // latched modulus
  logic [PW-1:0]     bits_q, bits_d;  // remaining dividend bits, next bit at MSB
  logic [CW-1:0]     cnt_q, cnt_d;    // iterations still to perform
  logic [WIDTH-1:0]  res_q, res_d;    // result presented in DONE
  logic              err_q, err_d;    // zero-modulus flag presented in DONE

  // Operand views used when deciding between the fast and full start.
  logic [WIDTH-1:0]  p_hi;
  logic [WIDTH-1:0]  p_lo;
  logic              fast_start;

  assign p_hi       = in_p[PW-1 -: WIDTH];
  assign p_lo       = in_p[WIDTH-1:0];
  assign fast_start = (p_hi < in_m);

  // One restoring step: shift in the next dividend bit, subtract M if it fits.
  // Because r < M < 2^WIDTH before the step, the shifted value fits WIDTH+1 bits.
  logic [WIDTH:0]    r_shift;
  logic [WIDTH:0]    r_sub;
  logic [WIDTH:0]    r_next;
  logic              r_ge_m;

  assign r_shift = (r_q << 1) | {{WIDTH{1'b0}}, bits_q[PW-1]};
  assign r_ge_m  = (r_shift >= {1'b0, m_q});
  assign r_sub   = r_shift - {1'b0, m_q};
  assign r_next  = r_ge_m ? r_sub : r_shift;

  // Next-state and datapath update for IDLE/RUN/DONE.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    m_d     = m_q;
    bits_d  = bits_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          m_d = in_m;
          if (in_m == '0) begin
            // Division by zero: report the error without iterating.
            res_d   = '0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (fast_start) begin
            // High half is already a valid remainder; only the low half remains.
            r_d     = {1'b0, p_hi};
            bits_d  = {p_lo, {WIDTH{1'b0}}};
            cnt_d   = CW'(WIDTH);
            state_d = S_RUN;
          end else begin
            r_d     = '0;
            bits_d  = in_p;
            cnt_d   = CW'(PW);
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        r_d    = r_next;
        bits_d = {bits_q[PW-2:0], 1'b0};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_d   = r_next[WIDTH-1:0];
          err_d   = 1'b0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // Result is held until the consumer takes it; no same-cycle re-accept.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      m_q     <= '0;
      bits_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      m_q     <= m_d;
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_r     = res_q;
  assign out_err   = err_q;

endmodule
`default_nettype wire

// File: doc/mod_reduce128.md
Name: mod_reduce128

Overview:
Sequential modular reduction stage that sits directly downstream of the 64x64 Karatsuba multiplier stage. It accepts the 2*WIDTH-bit product P and a WIDTH-bit modulus M, and returns R = P mod M. It uses bit-serial restoring reduction (one dividend bit per cycle) behind valid/ready handshakes on both sides, so the multiplier wrapper can stall on it.

Parameters:
WIDTH, 64, modulus/result width; product width is 2*WIDTH.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  reset, synchronous, active-high
in_valid  input  1  in_p/in_m valid
in_ready  output  1  block can accept a new operand pair
in_p  input  2*WIDTH  product to reduce
in_m  input  WIDTH  modulus
out_valid  output  1  out_r/out_err valid
out_ready  input  1  consumer accepts result
out_r  output  WIDTH  P mod M
out_err  output  1  M was zero; out_r forced to 0
busy  output  1  high in RUN or DONE

Behaviour:
- Reset: synchronous, active-high; overrides everything including mid-operation. After reset the state is IDLE, in_ready=1, out_valid=0, out_r=0, out_err=0, busy=0. An in-flight operation is discarded with no output.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. A transfer happens when in_valid && in_ready. On transfer, latch P, M and r.
- Zero modulus: if in_m==0, go straight to DONE with out_r=0 and out_err=1. out_valid goes high 1 cycle after acceptance.
- Fast start: if in_p[2W-1:W] < in_m, set r = in_p[2W-1:W] and N = WIDTH. The remaining bits are in_p[W-1:0].
- Full start: otherwise set r = 0 and N = 2*WIDTH. The remaining bits are all of in_p.
- RUN: one iteration per rising edge, MSB first.
  - r' = (r << 1) | next_bit.
  - If r' >= M then r = r' - M, else r = r'.
  - r is held at WIDTH+1 bits internally so the shift never overflows. The invariant r < M holds after every iteration.
  - Iteration counter counts N down. After the N-th iteration, go to DONE with out_r = r[W-1:0] and out_err=0.
- Latency: out_valid is first high exactly N cycles after the acceptance edge (64 or 128 for WIDTH=64), or 1 cycle for M==0.
- DONE: out_valid=1.
  - out_r and out_err are held stable while out_ready=0 (unbounded backpressure).
  - When out_valid && out_ready, go to IDLE next cycle. out_valid drops and in_ready rises.
  - There is no same-cycle accept in DONE; minimum issue interval is N+2 cycles.
- in_ready=0 throughout RUN and DONE. in_valid in those states is ignored and not queued.
- in_p and in_m need only be stable during the acceptance cycle.
- M==1 gives R=0 through the normal path. out_err is set only for M==0.
- Result is exact for all P < 2^(2W) and all M >= 1. Precondition P < M*2^W is not required; it only selects the fast path.

Test Plan:
- M=7, P=100, out_ready=1 -> fast path; out_valid high 64 cycles after accept; out_r=2, out_err=0; one-cycle pulse; in_ready back next cycle.
- M=3, P=2^127 -> full path (high half 2^63 >= 3); out_valid after 128 cycles; out_r=2.
- M=2^64-1, P=(2^64-2)^2 = 0xFFFFFFFFFFFFFFFC_0000000000000004 -> fast path; out_r=1 after 64 cycles.
- M=0, any P -> out_valid 1 cycle after accept, out_err=1, out_r=0. Then M=1, P=0xDEADBEEF -> out_r=0, out_err=0.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid: out_r remains stable and in_ready stays 0.
  - Pulse in_valid with different data during RUN: it is ignored and the result is unchanged.
  - Raise out_ready: return to IDLE next cycle.
- Reset mid-op: assert reset 20 cycles into RUN -> next cycle IDLE, out_valid=0, in_ready=1, out_r=0. A following M=7, P=100 still yields 2.
